// File: rtl/ram2reg_pkg.sv
// ram2reg shared types: load engine state encoding and
// address/select width helpers used by the top and its bus interface.
package ram2reg_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } eng_state_t;

    function automatic int addr_width(input int reg_num, input int buf_num);
        return (reg_num * buf_num > 1) ? $clog2(reg_num * buf_num) : 1;
    endfunction

    function automatic int sel_width(input int reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

endpackage

// File: rtl/ram2reg_if.sv
// ram2reg register bus: word-addressed read/write requests held
// by the master until a one-cycle reg_ready from the slave.
interface ram2reg_if
    import ram2reg_pkg::*;
#(
    parameter int AW = 10
);

    logic [AW-1:0]     reg_addr;
    logic [DATA_W-1:0] reg_writedata;
    logic              reg_wr;
    logic              reg_rd;
    logic              reg_ready;
    logic [DATA_W-1:0] reg_readdata;

    modport master (
        output reg_addr,
        output reg_writedata,
        output reg_wr,
        output reg_rd,
        input  reg_ready,
        input  reg_readdata
    );

    modport slave (
        input  reg_addr,
        input  reg_writedata,
        input  reg_wr,
        input  reg_rd,
        output reg_ready,
        output reg_readdata
    );

endinterface

// File: rtl/rowo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the old word.
module rowo_dpram #(
    parameter int rdw = 32,
    parameter int wdw = 32,
    parameter int raw = 10
) (
    input  logic           clk,
    input  logic           we,
    input  logic [raw-1:0] waddr,
    input  logic [wdw-1:0] wdata,
    input  logic           re,
    input  logic [raw-1:0] raddr,
    output logic [rdw-1:0] rdata
);

    logic [rdw-1:0] mem [2**raw];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram2reg.sv
// Buffer RAM written over the register bus; a load engine copies one
// REG_NUM-word sequence out of it into seq_reg in a single commit cycle.
module ram2reg
    import ram2reg_pkg::*;
#(
    parameter int REG_NUM = 10,
    parameter int BUF_NUM = 80,
    localparam int AW = addr_width(REG_NUM, BUF_NUM),
    localparam int SW = sel_width(REG_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ram2reg_if.slave                bus,
    input  logic [AW-1:0]           load_addr,
    input  logic                    load_trigger,
    output logic                    load_busy,
    output logic                    load_done,
    output logic [REG_NUM*32-1:0]   seq_reg
);

    eng_state_t state, state_nxt;

    logic [AW-1:0]     base;
    logic [SW-1:0]     idx;
    logic [SW-1:0]     cap_idx;
    logic              cap_vld;
    logic [DATA_W-1:0] staging [REG_NUM];
    logic [DATA_W-1:0] rdata;
    logic [AW-1:0]     raddr;
    logic              ready_q;
    logic              wr_go;
    logic              rd_go;
    logic              fetch;
    logic              last;

    assign fetch = (state == ST_FETCH);
    assign last  = (idx == SW'(REG_NUM - 1));

    // Writes never wait; reads only start while the engine is idle.
    assign wr_go = bus.reg_wr & ~ready_q;
    assign rd_go = bus.reg_rd & ~bus.reg_wr & ~ready_q
                 & (state == ST_IDLE);

    assign raddr = fetch ? AW'(base + AW'(idx)) : bus.reg_addr;

    assign bus.reg_ready    = ready_q;
    assign bus.reg_readdata = rdata;
    assign load_done        = (state == ST_COMMIT);
    assign load_busy        = load_trigger | (state != ST_IDLE);

    rowo_dpram #(
        .rdw (DATA_W),
        .wdw (DATA_W),
        .raw (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr (bus.reg_addr),
        .wdata (bus.reg_writedata),
        .re    (rd_go | fetch),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (load_trigger) state_nxt = ST_FETCH;
            ST_FETCH:  if (last) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base    <= '0;
            idx     <= '0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= wr_go | rd_go;
            cap_vld <= fetch;
            cap_idx <= idx;
            if (state == ST_IDLE && load_trigger) begin
                base <= load_addr;
                idx  <= '0;
            end else if (fetch) begin
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end

    // The last word is still in flight at commit, so it bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= '0;
            for (int i = 0; i < REG_NUM; i++) staging[i] <= '0;
        end else begin
            if (cap_vld) staging[cap_idx] <= rdata;
            if (state == ST_COMMIT) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    seq_reg[32*i +: 32] <= (i == REG_NUM - 1) ? rdata
                                                              : staging[i];
                end
            end
        end
    end

endmodule

// File: doc/ram2reg.md
RAM2REG -- requirements
Module: ram2reg

Interface
REQ-001 SHALL have parameter REG_NUM, default 10: number of 32-bit registers per sequence.
REQ-002 SHALL have parameter BUF_NUM, default 80: number of sequences buffered; aw=$clog2(REG_NUM*BUF_NUM), sw=$clog2(REG_NUM).
REQ-003 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port reg_addr  in  aw: bus word address into buffer RAM.
REQ-006 SHALL have port reg_writedata  in  32: bus write data.
REQ-007 SHALL have port reg_wr  in  1: bus write request, held until reg_ready.
REQ-008 SHALL have port reg_rd  in  1: bus read request, held until reg_ready.
REQ-009 SHALL have port reg_ready  out  1: one-cycle bus acknowledge.
REQ-010 SHALL have port reg_readdata  out  32: RAM word at reg_addr, valid while reg_ready high after a read.
REQ-011 SHALL have port load_addr  in  aw: base address of sequence to load.
REQ-012 SHALL have port load_trigger  in  1: single-cycle load start.
REQ-013 SHALL have port load_busy  out  1: load_trigger OR engine not IDLE.
REQ-014 SHALL have port load_done  out  1: one-cycle pulse when seq_reg updated.
REQ-015 SHALL have port seq_reg  out  REG_NUM*32: register image, word i at bits [32*i+31:32*i].

Function
REQ-016 SHALL store bus writes in dual-port RAM, 32x(REG_NUM*BUF_NUM), write port owned by bus, read port shared by bus and load engine.
REQ-017 Bus write: SHALL write RAM on first cycle reg_wr high with reg_ready low; reg_ready high the next cycle, then low; write never stalled by load engine.
REQ-018 Bus read when engine IDLE: read issued first cycle; reg_ready and valid reg_readdata the following cycle.
REQ-019 Bus read during load: reg_ready SHALL be withheld until engine returns IDLE, then follow REQ-018.
REQ-020 reg_rd and reg_wr both high SHALL be treated as a write.
REQ-021 Engine states: IDLE, FETCH, COMMIT. IDLE->FETCH on load_trigger (load_addr captured, index=0); FETCH issues address load_addr+index, index 0..REG_NUM-1, one per cycle; FETCH->COMMIT after last address; COMMIT->IDLE after one cycle.
REQ-022 Read data (1-cycle RAM latency) SHALL be captured into a staging array; seq_reg SHALL not change until COMMIT, when all REG_NUM words update in one cycle.
REQ-023 load_done SHALL pulse in the COMMIT cycle, REG_NUM+1 cycles after the trigger cycle; seq_reg shows new value from the following cycle.
REQ-024 load_trigger while engine not IDLE SHALL be ignored.
REQ-025 load_addr+index SHALL wrap modulo 2^aw.
REQ-026 Bus write and engine read at same address in same cycle SHALL return old data (read-before-write).

Reset
REQ-027 On rst_n low: engine IDLE, seq_reg=0, staging=0, reg_ready=0, load_done=0, load_busy=0 (except via load_trigger), index=0; RAM content not reset.
REQ-028 Reset mid-load SHALL abandon the load without updating seq_reg; pending bus transactions dropped.

Structure
REQ-029 Engine state encoding and aw/sw width functions SHALL live in shared package ram2reg_pkg.
REQ-030 RAM SHALL be the existing rowo_dpram instance (rdw=32, wdw=32, raw=aw); no other sub-module.

Verification
REQ-031 Write 0x1000+i to addresses 20..29, trigger load_addr=20 -> load_done 11 cycles later, seq_reg word i = 0x1000+i, all words change in the same cycle.
REQ-032 Bus read addr 5 during load -> reg_ready withheld until IDLE, then reg_readdata = stored value.
REQ-033 Second load_trigger 3 cycles into a load -> ignored; exactly one load_done.
REQ-034 load_addr = 2^aw-3 -> words fetched from 2^aw-3..2^aw-1 then 0..6.
REQ-035 rst_n low at FETCH index 4 -> seq_reg keeps prior value, no load_done, load_busy=0.
REQ-036 Bus write 0xDEAD to address being fetched in same cycle -> seq_reg gets old word; later load gets 0xDEAD.
